// File: rtl/reg_file.sv
// reg_file: NREG x DATA_W architectural register file with two operand read
// ports, a debug read port, one write-back port and a saturating count of
// committed writes.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   reset_n   - asynchronous active-low reset; clears all registers and wr_count
//   rs_addr   - read port A address (ALU first operand)
//   rt_addr   - read port B address (ALU second-operand mux)
//   wr_en     - write-back enable
//   wr_addr   - write-back destination register
//   wr_data   - write-back value
//   dbg_addr  - debug read port address
//   rs_data   - read port A data (combinational)
//   rt_data   - read port B data (combinational)
//   dbg_data  - debug read port data (combinational)
//   wr_count  - number of committed writes, saturating at all-ones
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic              commit;

    // A write commits only to an existing, nonzero register.
    assign commit = wr_en && (wr_addr != 5'd0) && (32'(wr_addr) < NREG);

    // Register 0 and out-of-range addresses read as zero. The bypass is gated
    // by reset_n so every port reads zero while reset is held, even with a
    // write pending.
    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != 5'd0 && 32'(addr) < NREG) begin
            if (commit && reset_n && addr == wr_addr) begin
                val = wr_data;
            end else begin
                val = regs_q[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rs_data  = read_port(rs_addr);
        rt_data  = read_port(rt_addr);
        dbg_data = read_port(dbg_addr);
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && wr_count_q != '1) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule
